dmux_stream: RTL and testbench

Parametrised 1-to-NUM_OUT stream demultiplexer, the registered and flow-controlled generalisation of the fixed 8-way single-bit demux gate.
Routes a WIDTH-bit word to one selected output, or to all outputs in broadcast mode, using a valid/ready handshake.
Each output has a one-entry holding slot, so a stalled output does not block traffic to other outputs.
Used as the front-end fan-out for memory-mapped peripheral channels in the Hack system.

---
 rtl/dmux_stream_pkg.sv | 14 +
 rtl/dmux_stream_slot.sv | 46 ++++
 rtl/dmux_stream.sv | 94 +++++++++
 tb/tb_dmux_stream.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmux_stream_pkg.sv
// Shared constants and helpers for the Hack stream fan-out blocks.
package dmux_stream_pkg;

    localparam int WORD_W = 16;

    // Ceiling log2, never less than 1 so a select port always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/dmux_stream_slot.sv
// Single-channel holding register: one word plus an occupied flag.
// A load and a drain on the same edge keep the slot full with the new word.
module dmux_stream_slot
    import dmux_stream_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             free
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign free      = ~valid_q | out_ready;

endmodule

// File: rtl/dmux_stream.sv
// 1-to-NUM_OUT registered stream demultiplexer with per-channel holding slots,
// all-or-nothing broadcast and a saturating count of out-of-range drops.
module dmux_stream
    import dmux_stream_pkg::*;
#(
    parameter  int WIDTH   = WORD_W,
    parameter  int NUM_OUT = 8,
    localparam int SEL_W   = clog2(NUM_OUT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_bcast,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic [NUM_OUT*WIDTH-1:0] out_data,
    output logic [7:0]               err_cnt
);

    localparam int SEL_SPAN = 1 << SEL_W;

    logic [NUM_OUT-1:0]  free;
    logic [NUM_OUT-1:0]  load;
    logic [SEL_SPAN-1:0] free_pad;
    logic                in_range;
    logic                accept;
    logic [7:0]          err_cnt_q, err_cnt_d;

    // With a power-of-two channel count every select value addresses a slot.
    if (SEL_SPAN == NUM_OUT) begin : g_pow2
        assign in_range = 1'b1;
    end else begin : g_npow2
        assign in_range = (int'(in_sel) < NUM_OUT);
    end

    always_comb begin
        free_pad                = '0;
        free_pad[NUM_OUT-1:0]   = free;
        if (reset) begin
            in_ready = 1'b0;
        end else if (in_bcast) begin
            in_ready = &free;
        end else if (in_range) begin
            in_ready = free_pad[in_sel];
        end else begin
            in_ready = 1'b1;
        end
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        load = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            load[k] = accept & (in_bcast | (in_range & (in_sel == SEL_W'(k))));
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && !in_bcast && !in_range && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        dmux_stream_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .load     (load[k]),
            .load_data(in_data),
            .out_ready(out_ready[k]),
            .out_valid(out_valid[k]),
            .out_data (out_data[k*WIDTH +: WIDTH]),
            .free     (free[k])
        );
    end

endmodule

// File: tb/tb_dmux_stream.sv
// Bench for dmux_stream: directed scenarios plus randomized traffic on an
// 8-channel and a 6-channel instance, checked against a slot-array model.
module tb_dmux_stream;

    localparam int W  = 16;
    localparam int N  = 8;
    localparam int N6 = 6;
    localparam int S  = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic           in_valid, in_ready, in_bcast;
    logic [W-1:0]   in_data;
    logic [S-1:0]   in_sel;
    logic [N-1:0]   out_valid, out_ready;
    logic [N*W-1:0] out_data;
    logic [7:0]     err_cnt;

    logic            in_valid6, in_ready6, in_bcast6;
    logic [W-1:0]    in_data6;
    logic [S-1:0]    in_sel6;
    logic [N6-1:0]   out_valid6, out_ready6;
    logic [N6*W-1:0] out_data6;
    logic [7:0]      err_cnt6;

    dmux_stream #(.WIDTH(W), .NUM_OUT(N)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err_cnt(err_cnt)
    );

    dmux_stream #(.WIDTH(W), .NUM_OUT(N6)) u_dut6 (
        .clk(clk), .reset(reset), .in_valid(in_valid6), .in_ready(in_ready6),
        .in_data(in_data6), .in_sel(in_sel6), .in_bcast(in_bcast6),
        .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6), .err_cnt(err_cnt6)
    );

    // Reference state: what each channel holds and whether its data is defined.
    bit           mv[N];
    logic [W-1:0] md[N];
    bit           mk[N];
    bit           mv6[N6];
    logic [W-1:0] md6[N6];
    bit           mk6[N6];
    int           err6;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_ready();
        if (reset) return 1'b0;
        if (in_bcast) begin
            for (int k = 0; k < N; k++) if (mv[k] && !out_ready[k]) return 1'b0;
            return 1'b1;
        end
        return !mv[in_sel] || out_ready[in_sel];
    endfunction

    task automatic check_all();
        logic [N-1:0]    ev;
        logic [N*W-1:0]  em, ed;
        logic [N6-1:0]   ev6;
        logic [N6*W-1:0] em6, ed6;
        for (int k = 0; k < N; k++) begin
            ev[k]         = mv[k];
            em[k*W +: W]  = {W{mk[k]}};
            ed[k*W +: W]  = md[k];
        end
        for (int k = 0; k < N6; k++) begin
            ev6[k]        = mv6[k];
            em6[k*W +: W] = {W{mk6[k]}};
            ed6[k*W +: W] = md6[k];
        end
        chk("out_valid", out_valid, ev);
        chk("out_data", out_data & em, ed & em);
        chk("data_known", $isunknown(out_data), 1'b0);
        chk("in_ready", in_ready, exp_ready());
        chk("err_cnt", err_cnt, 8'd0);
        chk("out_valid6", out_valid6, ev6);
        chk("out_data6", out_data6 & em6, ed6 & em6);
        chk("in_ready6", in_ready6, !reset);
        chk("err_cnt6", err_cnt6, err6[7:0]);
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin mv[k] = 0; md[k] = '0; mk[k] = 1; end
        for (int k = 0; k < N6; k++) begin mv6[k] = 0; md6[k] = '0; mk6[k] = 1; end
        err6 = 0;
    endtask

    task automatic model_edge();
        logic acc;
        if (reset) begin
            model_reset();
            return;
        end
        acc = in_valid && exp_ready();
        for (int k = 0; k < N; k++) begin
            if (acc && (in_bcast || in_sel == k)) begin
                mv[k] = 1; md[k] = in_data; mk[k] = 1;
            end else if (mv[k] && out_ready[k]) begin
                mv[k] = 0; mk[k] = 0;
            end
        end
        for (int k = 0; k < N6; k++) begin
            if (in_valid6 && in_sel6 == k) begin
                mv6[k] = 1; md6[k] = in_data6; mk6[k] = 1;
            end else if (mv6[k] && out_ready6[k]) begin
                mv6[k] = 0; mk6[k] = 0;
            end
        end
        if (in_valid6 && in_sel6 >= N6 && err6 < 255) err6++;
    endtask

    task automatic step();
        #1;
        check_all();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input int sel, input logic [W-1:0] d,
                         input logic b, input logic [N-1:0] r);
        in_valid  = v;
        in_sel    = S'(sel);
        in_data   = d;
        in_bcast  = b;
        out_ready = r;
    endtask

    initial begin
        reset      = 1'b1;
        drive(1'b0, 0, '0, 1'b0, '1);
        in_valid6  = 1'b0;
        in_sel6    = '0;
        in_data6   = '0;
        in_bcast6  = 1'b0;
        out_ready6 = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        step();
        reset = 1'b0;

        // Out-of-range flood on the 6-channel instance saturates its drop counter.
        in_valid6 = 1'b1;
        in_sel6   = 3'd7;
        for (int i = 0; i < 300; i++) step();
        #1;
        chk("s5_err_sat", err_cnt6, 8'd255);
        chk("s5_no_out", out_valid6, '0);
        in_valid6 = 1'b0;

        // Unicast delivery with one-cycle latency.
        drive(1'b1, 5, 16'hBEEF, 1'b0, 8'hFF);
        step();
        chk("s1_vld", out_valid, 8'b0010_0000);
        chk("s1_data", out_data[5*W +: W], 16'hBEEF);
        drive(1'b0, 0, '0, 1'b0, 8'hFF);
        step();
        chk("s1_clr", out_valid, 8'h00);

        // Back-pressure on channel 2, with channel 6 unaffected.
        drive(1'b1, 2, 16'h0001, 1'b0, 8'hFB);
        step();
        drive(1'b1, 2, 16'h0002, 1'b0, 8'hFB);
        #1 chk("s2_blocked", in_ready, 1'b0);
        step();
        step();
        chk("s2_hold", out_data[2*W +: W], 16'h0001);
        drive(1'b1, 6, 16'h1234, 1'b0, 8'hFB);
        #1 chk("s3_rdy", in_ready, 1'b1);
        step();
        chk("s3_vld", out_valid, 8'b0100_0100);
        chk("s3_data", out_data[6*W +: W], 16'h1234);
        drive(1'b1, 2, 16'h0002, 1'b0, 8'hFF);
        #1 chk("s2_rdy_drain", in_ready, 1'b1);
        step();
        chk("s2_stay_vld", out_valid[2], 1'b1);
        chk("s2_data2", out_data[2*W +: W], 16'h0002);
        drive(1'b0, 0, '0, 1'b0, 8'hFF);
        step();
        chk("s2_empty", out_valid, 8'h00);

        // Broadcast waits until every slot is free, then loads all at once.
        drive(1'b1, 3, 16'h3333, 1'b0, 8'hF7);
        step();
        drive(1'b1, 0, 16'hA5A5, 1'b1, 8'hF7);
        #1 chk("s4_blocked", in_ready, 1'b0);
        step();
        chk("s4_none", out_valid, 8'h08);
        chk("s4_keep3", out_data[3*W +: W], 16'h3333);
        drive(1'b1, 0, 16'hA5A5, 1'b1, 8'hFF);
        step();
        chk("s4_all_vld", out_valid, 8'hFF);
        chk("s4_all_data", out_data, {N{16'hA5A5}});
        drive(1'b0, 0, '0, 1'b0, 8'hFF);
        step();

        // Reset while slots are full and a word is offered.
        drive(1'b1, 0, 16'h0A0A, 1'b0, 8'h00);
        step();
        drive(1'b1, 1, 16'h1B1B, 1'b0, 8'h00);
        step();
        drive(1'b1, 7, 16'h7C7C, 1'b0, 8'h00);
        step();
        chk("s6_full", out_valid, 8'h83);
        reset = 1'b1;
        in_valid6 = 1'b1;
        drive(1'b1, 4, 16'h4444, 1'b0, 8'h00);
        step();
        reset = 1'b0;
        in_valid6 = 1'b0;
        drive(1'b0, 0, '0, 1'b0, 8'h00);
        #1;
        chk("s6_vld", out_valid, 8'h00);
        chk("s6_data", out_data, '0);
        chk("s6_err", err_cnt, 8'd0);
        chk("s6_err6", err_cnt6, 8'd0);
        step();

        // Randomized traffic, occasional reset.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), W'($urandom),
                  ($urandom_range(0, 7) == 0), N'($urandom) | N'($urandom));
            in_valid6 = 1'($urandom_range(0, 1));
            in_sel6   = S'($urandom_range(0, 7));
            in_data6  = W'($urandom);
            step();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
